pe_weight_loader: RTL
=====================

// Module: pe_weight_loader
// PURPOSE
// - Drives the weight and control side of a PE_row column stack: accepts one weight row per beat
//   (valid/ready), shifts it down the column via out_weight/w_en, then asserts w_compute for a
//   programmed number of cycles.
// - Sits between the weight buffer and the top PE_row of a weight-stationary systolic tile.
// PARAMETERS
// - data_width          22   bits per weight element
// - w_tile_column_size  16   PEs per row (elements per weight row)
// - w_tile_row_size     16   PE rows in the column stack (rows to load per tile)
// - len_width           16   width of compute_len
// PORTS
// - clk             in   1                              rising-edge clock
// - rst_n           in   1                              asynchronous active-low reset
// - start           in   1                              begin a tile; sampled only in IDLE
// - abort           in   1                              synchronous cancel, any state
// - compute_len     in   len_width                      compute cycles; latched on accepted start
// - in_valid        in   1                              in_weight_row is valid
// - in_ready        out  1                              loader accepts a row this cycle
// - in_weight_row   in   data_width*w_tile_column_size  one weight row
// - out_weight      out  data_width*w_tile_column_size  to in_weight_above of top PE_row
// - w_en            out  1                              shift-enable to all PE_rows
// - w_compute       out  1                              compute-enable to all PE_rows
// - busy            out  1                              high in any state except IDLE
// - done            out  1                              1-cycle pulse at end of tile
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; out_weight=0, w_en=0, w_compute=0, in_ready=0, busy=0,
//   done=0, row and compute counters 0. Reset mid-tile discards all progress.
// - FSM: IDLE -> LOAD on start. LOAD -> COMPUTE when row count reaches w_tile_row_size
//   (-> DONE if latched compute_len==0). COMPUTE -> DONE after compute_len cycles. DONE -> IDLE.
// - IDLE: in_ready=0. start while busy is ignored (no queueing).
// - LOAD: in_ready=1 combinationally while row count < w_tile_row_size.
//   - Accept = in_valid & in_ready.
//   - On accept: out_weight <= in_weight_row and w_en <= 1 (registered, 1-cycle latency).
//   - On a non-accept cycle: w_en <= 0, out_weight holds. Gaps never shift the chain.
// - Row ordering: the first accepted row ends in the bottom PE_row. The producer sends the last
//   matrix row first.
// - First COMPUTE cycle: w_en=0 (last load beat has drained). w_compute=1 for exactly
//   compute_len consecutive cycles. w_en and w_compute are never high in the same cycle.
// - DONE: done=1 for one cycle, w_compute=0, busy=1. Next cycle IDLE, busy=0.
// - abort in LOAD/COMPUTE/DONE: next cycle IDLE, with w_en=0, w_compute=0, in_ready=0, done=0
//   and counters cleared. PE contents are left as-is. abort has priority over start and accept.
// - abort together with start in IDLE: start is ignored.
// - Counters: the row counter is $clog2(w_tile_row_size+1) bits and saturates at
//   w_tile_row_size (no wrap). The compute counter is len_width bits. compute_len of all-ones
//   is legal.
// - out_weight is a straight register copy (no arithmetic). No partial-sum handling here;
//   in_sum/out_sum stay in PE_row.
// STRUCTURE
// - Shared package systolic_pkg holds:
//   - loader_state_t enum {IDLE, LOAD, COMPUTE, DONE}
//   - default DATA_WIDTH=22, TILE_COLS=16, TILE_ROWS=16
//   - function clog2 for counter widths
// - Single module, no sub-modules. FSM, row counter, compute counter and output register
//   all live here.
// TESTING (cross-check against PE_row stack of 16x16, data_width=22)
// - Reset: hold rst_n=0 with in_valid=1, start=1 -> all outputs 0. Release -> IDLE, in_ready=0.
// - Back-to-back load: start, compute_len=5, 16 rows with continuous in_valid.
//   -> 16 w_en cycles, each lagging its accept by 1.
//   -> then w_compute high exactly 5 cycles, then done for 1 cycle.
//   -> bottom PE_row holds the first row sent.
// - Gapped load: in_valid toggles 1,0,0,1 ... -> w_en high only the cycle after each accept.
//   -> out_weight stable across gaps; total w_en count 16; in_ready drops after the 16th accept.
// - compute_len=0: after the 16th row -> DONE directly. w_compute never asserts; done pulses once.
// - Abort: abort at row 7 of LOAD -> next cycle IDLE, w_en=0, in_ready=0, busy=0, no done.
//   -> a new start reloads all 16 rows.
// - Abort at compute cycle 2 of 5 -> w_compute=0 next cycle, no done.
// - start pulsed during COMPUTE -> ignored; exactly one done; no second tile begins.

Source files
------------

// File: rtl/pe_weight_loader_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the weight-stationary systolic tile.
//   loader_state_t : weight loader FSM states
//   DATA_WIDTH     : default bits per weight element
//   TILE_COLS      : default PEs per row (elements per weight row)
//   TILE_ROWS      : default PE rows in the column stack
//   LEN_WIDTH      : default width of the compute-length field
//   clog2()        : ceiling log2, used to size counters
// ---------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

  localparam int DATA_WIDTH = 22;
  localparam int TILE_COLS  = 16;
  localparam int TILE_ROWS  = 16;
  localparam int LEN_WIDTH  = 16;

  // Number of bits needed to encode values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pe_weight_loader_if.sv
// ---------------------------------------------------------------------------
// pe_weight_loader_if
// Control, weight-row handshake and PE-side outputs of the weight loader.
//   start, abort, compute_len         : tile control from the sequencer
//   in_valid, in_ready, in_weight_row : weight-buffer handshake, one row per beat
//   out_weight, w_en, w_compute       : drive the top PE_row of the column stack
//   busy, done                        : status back to the sequencer
// master = sequencer/buffer side, slave = loader side.
// ---------------------------------------------------------------------------
interface pe_weight_loader_if #(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int TILE_COLS  = systolic_pkg::TILE_COLS,
  parameter int LEN_WIDTH  = systolic_pkg::LEN_WIDTH
) ();

  logic                            start;
  logic                            abort;
  logic [LEN_WIDTH-1:0]            compute_len;
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_WIDTH*TILE_COLS-1:0] in_weight_row;
  logic [DATA_WIDTH*TILE_COLS-1:0] out_weight;
  logic                            w_en;
  logic                            w_compute;
  logic                            busy;
  logic                            done;

  modport master (
    output start, abort, compute_len, in_valid, in_weight_row,
    input  in_ready, out_weight, w_en, w_compute, busy, done
  );

  modport slave (
    input  start, abort, compute_len, in_valid, in_weight_row,
    output in_ready, out_weight, w_en, w_compute, busy, done
  );

endinterface

// File: rtl/pe_weight_loader.sv
// ---------------------------------------------------------------------------
// pe_weight_loader
// Loads one weight tile into a PE_row column stack and then runs it.
// Rows arrive one per beat on a valid/ready handshake and are shifted down the
// column through out_weight/w_en; once the stack is full, w_compute is held
// for compute_len cycles and done pulses once.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pe_weight_loader_if.slave (start, abort, compute_len, in_valid,
//           in_ready, in_weight_row, out_weight, w_en, w_compute, busy, done)
// ---------------------------------------------------------------------------
module pe_weight_loader
  import systolic_pkg::*;
#(
  parameter int data_width         = DATA_WIDTH,
  parameter int w_tile_column_size = TILE_COLS,
  parameter int w_tile_row_size    = TILE_ROWS,
  parameter int len_width          = LEN_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_weight_loader_if.slave bus
);

  localparam int ROW_CNT_W = clog2(w_tile_row_size + 1);
  localparam int ROW_W     = data_width * w_tile_column_size;
  localparam logic [ROW_CNT_W-1:0] ROWS_FULL = ROW_CNT_W'(w_tile_row_size);

  loader_state_t          r_state;
  loader_state_t          w_nextState;
  logic [ROW_CNT_W-1:0]   r_rowCnt;
  logic [len_width-1:0]   r_compCnt;
  logic [len_width-1:0]   r_computeLen;
  logic [ROW_W-1:0]       r_outWeight;
  logic                   r_wEn;

  logic w_rowsFull;
  logic w_ready;
  logic w_accept;
  logic w_computeLast;

  assign w_rowsFull    = (r_rowCnt == ROWS_FULL);
  // abort is folded into ready so a row offered in the abort cycle is not
  // consumed by the producer and never reaches the column.
  assign w_ready       = (r_state == LOAD) && !w_rowsFull && !bus.abort;
  assign w_accept      = w_ready && bus.in_valid;
  // Only evaluated in COMPUTE, where the latched length is known to be nonzero.
  assign w_computeLast = (r_compCnt == (r_computeLen - len_width'(1)));

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_nextState = LOAD;
      end
      // LOAD lingers one cycle after the last accept so that the final w_en
      // beat drains before w_compute rises.
      LOAD: begin
        if (w_rowsFull) begin
          w_nextState = (r_computeLen == '0) ? DONE : COMPUTE;
        end
      end
      COMPUTE: begin
        if (w_computeLast) w_nextState = DONE;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (bus.abort) w_nextState = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: output register, shift enable and the two counters.
  // The row counter cannot pass ROWS_FULL because accepts stop there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rowCnt     <= '0;
      r_compCnt    <= '0;
      r_computeLen <= '0;
      r_outWeight  <= '0;
      r_wEn        <= 1'b0;
    end else if (bus.abort) begin
      r_rowCnt  <= '0;
      r_compCnt <= '0;
      r_wEn     <= 1'b0;
    end else begin
      r_wEn <= w_accept;
      if (w_accept) begin
        r_outWeight <= bus.in_weight_row;
        r_rowCnt    <= r_rowCnt + ROW_CNT_W'(1);
      end
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_computeLen <= bus.compute_len;
            r_rowCnt     <= '0;
            r_compCnt    <= '0;
          end
        end
        COMPUTE: begin
          r_compCnt <= w_computeLast ? '0 : (r_compCnt + len_width'(1));
        end
        DONE: begin
          r_rowCnt  <= '0;
          r_compCnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_weight = r_outWeight;
  assign bus.w_en       = r_wEn;
  assign bus.w_compute  = (r_state == COMPUTE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);

endmodule
